// File: rtl/assoc_wb_cache_pkg.sv
// Shared types and derived geometry for the set-associative write-back cache.
// The default geometry is 2 ways x 4 sets x 4 words over a 1K-word memory.
package assoc_wb_cache_pkg;

    function automatic int unsigned calc_set_bits(input int unsigned cache_bits,
                                                  input int unsigned block_bits,
                                                  input int unsigned asoc_bits);
        return cache_bits - block_bits - asoc_bits;
    endfunction

    function automatic int unsigned calc_tag_bits(input int unsigned ram_bits,
                                                  input int unsigned cache_bits,
                                                  input int unsigned asoc_bits);
        return ram_bits - (cache_bits - asoc_bits);
    endfunction

    localparam int unsigned DEF_RAM_ADDRESS_BITS   = 10;
    localparam int unsigned DEF_CACHE_ADDRESS_BITS = 5;
    localparam int unsigned DEF_ASOC_BITS          = 1;
    localparam int unsigned DEF_BLOCK_BITS         = 2;

    localparam int unsigned SET_BITS = calc_set_bits(DEF_CACHE_ADDRESS_BITS, DEF_BLOCK_BITS,
                                                     DEF_ASOC_BITS);
    localparam int unsigned TAG_BITS = calc_tag_bits(DEF_RAM_ADDRESS_BITS,
                                                     DEF_CACHE_ADDRESS_BITS, DEF_ASOC_BITS);
    localparam int unsigned WAYS     = 1 << DEF_ASOC_BITS;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_WRITEBACK = 2'd1;
    localparam state_t ST_REFILL    = 2'd2;
    localparam state_t ST_RESPOND   = 2'd3;

    typedef struct packed {
        logic valid;
        logic dirty;
    } line_meta_t;

endpackage

// File: rtl/cache_lru.sv
// True-LRU age table: per set, each way holds an age (0 = MRU, all-ones = LRU).
// Ages always form a permutation of 0..ways-1, starting at the identity after reset.
module cache_lru
    import assoc_wb_cache_pkg::*;
#(
    parameter int unsigned SetBits = 2,
    parameter int unsigned WayBits = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               touch_en_i,
    input  logic [SetBits-1:0] touch_set_i,
    input  logic [WayBits-1:0] touch_way_i,
    input  logic [SetBits-1:0] query_set_i,
    output logic [WayBits-1:0] victim_way_o
);
    localparam int unsigned NumSets = 1 << SetBits;
    localparam int unsigned NumWays = 1 << WayBits;

    logic [WayBits-1:0] age_q [NumSets][NumWays];
    logic [WayBits-1:0] age_d [NumSets][NumWays];
    logic [WayBits-1:0] touched_age;

    always_comb begin
        age_d       = age_q;
        touched_age = age_q[touch_set_i][touch_way_i];
        if (touch_en_i) begin
            for (int w = 0; w < NumWays; w++) begin
                if (WayBits'(w) == touch_way_i) begin
                    age_d[touch_set_i][w] = '0;
                end else if (age_q[touch_set_i][w] < touched_age) begin
                    age_d[touch_set_i][w] = age_q[touch_set_i][w] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        victim_way_o = '0;
        for (int w = 0; w < NumWays; w++) begin
            if (age_q[query_set_i][w] == '1) begin
                victim_way_o = WayBits'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NumSets; s++) begin
                for (int w = 0; w < NumWays; w++) begin
                    age_q[s][w] <= WayBits'(w);
                end
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/assoc_wb_cache.sv
// Set-associative write-back / write-allocate cache with true LRU replacement.
// Hits complete one cycle after acceptance; misses stall through writeback and refill.
module assoc_wb_cache
    import assoc_wb_cache_pkg::*;
#(
    parameter int unsigned RAM_ADDRESS_BITS   = 10,
    parameter int unsigned CACHE_ADDRESS_BITS = 5,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned ASOC_BITS          = 1,
    parameter int unsigned BLOCK_BITS         = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        read_en,
    input  logic                        write_en,
    input  logic [RAM_ADDRESS_BITS-1:0] address,
    input  logic [DATA_WIDTH-1:0]       write_data,
    output logic                        ready,
    output logic [DATA_WIDTH-1:0]       read_data,
    output logic                        valid,
    output logic                        miss,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [RAM_ADDRESS_BITS-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic                        mem_ack,
    input  logic [DATA_WIDTH-1:0]       mem_rdata
);
    localparam int unsigned SET_W      = calc_set_bits(CACHE_ADDRESS_BITS, BLOCK_BITS, ASOC_BITS);
    localparam int unsigned TAG_W      = calc_tag_bits(RAM_ADDRESS_BITS, CACHE_ADDRESS_BITS,
                                                       ASOC_BITS);
    localparam int unsigned NUM_WAYS   = 1 << ASOC_BITS;
    localparam int unsigned NUM_SETS   = 1 << SET_W;
    localparam int unsigned LINE_WORDS = 1 << BLOCK_BITS;
    localparam int unsigned LINE_W     = ASOC_BITS + SET_W;
    localparam int unsigned NUM_LINES  = 1 << LINE_W;

    // Line storage, addressed by {way, set}.
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES][LINE_WORDS];
    logic [DATA_WIDTH-1:0] data_d [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [TAG_W-1:0]      tag_d  [NUM_LINES];
    line_meta_t            meta_q [NUM_LINES];
    line_meta_t            meta_d [NUM_LINES];

    state_t                      state_q, state_d;
    logic                        req_we_q, req_we_d;
    logic [RAM_ADDRESS_BITS-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]       req_wdata_q, req_wdata_d;
    logic [ASOC_BITS-1:0]        victim_q, victim_d;
    logic [BLOCK_BITS-1:0]       cnt_q, cnt_d;
    logic                        valid_q, valid_d;
    logic                        miss_q, miss_d;
    logic [DATA_WIDTH-1:0]       read_data_q, read_data_d;

    logic [BLOCK_BITS-1:0] a_off, r_off;
    logic [SET_W-1:0]      a_idx, r_idx;
    logic [TAG_W-1:0]      a_tag, r_tag;

    assign a_off = address[BLOCK_BITS-1:0];
    assign a_idx = address[BLOCK_BITS +: SET_W];
    assign a_tag = address[RAM_ADDRESS_BITS-1 -: TAG_W];
    assign r_off = req_addr_q[BLOCK_BITS-1:0];
    assign r_idx = req_addr_q[BLOCK_BITS +: SET_W];
    assign r_tag = req_addr_q[RAM_ADDRESS_BITS-1 -: TAG_W];

    logic                 hit, inv_found;
    logic [ASOC_BITS-1:0] hit_way, inv_way, lru_way, victim_nx;
    logic [LINE_W-1:0]    v_line, v_line_nx;

    always_comb begin
        logic [LINE_W-1:0] ln;
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            ln = {ASOC_BITS'(w), a_idx};
            if (meta_q[ln].valid && tag_q[ln] == a_tag) begin
                hit     = 1'b1;
                hit_way = ASOC_BITS'(w);
            end
            if (!meta_q[ln].valid && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = ASOC_BITS'(w);
            end
        end
    end

    assign victim_nx = inv_found ? inv_way : lru_way;
    assign v_line_nx = {victim_nx, a_idx};
    assign v_line    = {victim_q, r_idx};

    logic                  acc_en, acc_we;
    logic [ASOC_BITS-1:0]  acc_way;
    logic [SET_W-1:0]      acc_idx;
    logic [BLOCK_BITS-1:0] acc_off;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [LINE_W-1:0]     acc_line;

    cache_lru #(
        .SetBits (SET_W),
        .WayBits (ASOC_BITS)
    ) u_lru (
        .clk          (clk),
        .reset        (reset),
        .touch_en_i   (acc_en),
        .touch_set_i  (acc_idx),
        .touch_way_i  (acc_way),
        .query_set_i  (a_idx),
        .victim_way_o (lru_way)
    );

    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        victim_d    = victim_q;
        cnt_d       = cnt_q;
        valid_d     = 1'b0;
        miss_d      = 1'b0;
        read_data_d = read_data_q;
        data_d      = data_q;
        tag_d       = tag_q;
        meta_d      = meta_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        acc_en      = 1'b0;
        acc_we      = 1'b0;
        acc_way     = '0;
        acc_idx     = '0;
        acc_off     = '0;
        acc_wdata   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (read_en || write_en) begin
                    if (hit) begin
                        acc_en    = 1'b1;
                        acc_we    = write_en;
                        acc_way   = hit_way;
                        acc_idx   = a_idx;
                        acc_off   = a_off;
                        acc_wdata = write_data;
                    end else begin
                        miss_d      = 1'b1;
                        req_we_d    = write_en;
                        req_addr_d  = address;
                        req_wdata_d = write_data;
                        victim_d    = victim_nx;
                        cnt_d       = '0;
                        state_d     = (meta_q[v_line_nx].valid && meta_q[v_line_nx].dirty) ?
                                      ST_WRITEBACK : ST_REFILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[v_line], r_idx, cnt_q};
                mem_wdata = data_q[v_line][cnt_q];
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_tag, r_idx, cnt_q};
                if (mem_ack) begin
                    data_d[v_line][cnt_q] = mem_rdata;
                    cnt_d                 = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        tag_d[v_line]  = r_tag;
                        meta_d[v_line] = '{valid: 1'b1, dirty: 1'b0};
                        state_d        = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: begin
                acc_en    = 1'b1;
                acc_we    = req_we_q;
                acc_way   = victim_q;
                acc_idx   = r_idx;
                acc_off   = r_off;
                acc_wdata = req_wdata_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Hits and the replayed miss share one completion path (data, dirty, LRU, valid).
        acc_line = {acc_way, acc_idx};
        if (acc_en) begin
            valid_d = 1'b1;
            if (acc_we) begin
                data_d[acc_line][acc_off] = acc_wdata;
                meta_d[acc_line].dirty    = 1'b1;
            end else begin
                read_data_d = data_q[acc_line][acc_off];
            end
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign valid     = valid_q;
    assign miss      = miss_q;
    assign read_data = read_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            victim_q    <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            miss_q      <= 1'b0;
            read_data_q <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                meta_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            victim_q    <= victim_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            miss_q      <= miss_d;
            read_data_q <= read_data_d;
            meta_q      <= meta_d;
        end
    end

    // Payload is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Scoreboard bench: requests push expected responses and memory transfers;
// a monitor and a memory responder pop and compare independently.
module tb_assoc_wb_cache;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic [9:0]  address = '0;
    logic [31:0] write_data = '0;
    logic        ready;
    logic [31:0] read_data;
    logic        valid;
    logic        miss;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    assoc_wb_cache dut (
        .clk        (clk),
        .reset      (reset),
        .read_en    (read_en),
        .write_en   (write_en),
        .address    (address),
        .write_data (write_data),
        .ready      (ready),
        .read_data  (read_data),
        .valid      (valid),
        .miss       (miss),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] data;
        logic        exp_miss;
        int          acc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] data;
    } xfer_t;

    exp_t        sb[$];
    xfer_t       mq[$];
    logic [31:0] mem [1024];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          max_delay = 0;
    int          rd_acks = 0;
    logic        miss_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Monitor: pops one expectation per valid pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid && miss) fail("valid_and_miss_together");
            if (miss) begin
                if (sb.size() == 0) begin
                    fail("unexpected_miss");
                end else begin
                    check("miss_expected", sb[0].exp_miss, 1'b1);
                    check("miss_latency", cyc, sb[0].acc + 1);
                    check("single_miss_pulse", miss_seen, 1'b0);
                    miss_seen = 1'b1;
                end
            end
            if (valid) begin
                if (sb.size() == 0) begin
                    fail("unexpected_valid");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("miss_before_valid", miss_seen, e.exp_miss);
                    if (!e.exp_miss) check("hit_latency", cyc, e.acc + 1);
                    if (!e.we) check("read_data", read_data, e.data);
                    miss_seen = 1'b0;
                end
            end
        end
    end

    // Memory responder with 0..max_delay cycles of ack latency.
    initial begin
        logic        cap_we;
        logic [9:0]  cap_addr;
        logic [31:0] cap_wd;
        logic        aborted;
        int          dly;
        xfer_t       x;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !reset) begin
                cap_we   = mem_we;
                cap_addr = mem_addr;
                cap_wd   = mem_wdata;
                aborted  = 1'b0;
                dly      = int'($urandom_range(max_delay, 0));
                for (int k = 0; k < dly; k++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("mem_req_held", mem_req, 1'b1);
                    check("mem_fields_stable", {mem_we, mem_addr, mem_wdata},
                          {cap_we, cap_addr, cap_wd});
                end
                if (!aborted) begin
                    if (mq.size() == 0) begin
                        fail("unexpected_mem_xfer");
                    end else begin
                        x = mq.pop_front();
                        check("mem_xfer_we", cap_we, x.we);
                        check("mem_xfer_addr", cap_addr, x.addr);
                        if (x.we) check("mem_xfer_wdata", cap_wd, x.data);
                    end
                    if (cap_we) mem[cap_addr] = cap_wd;
                    else mem_rdata = mem[cap_addr];
                    mem_ack = 1'b1;
                    @(posedge clk);
                    #1;
                    mem_ack = 1'b0;
                    if (!cap_we) rd_acks++;
                end
            end
        end
    end

    task automatic exp_refill(input logic [9:0] base);
        for (int i = 0; i < 4; i++) mq.push_back('{1'b0, base + 10'(i), 32'h0});
    endtask

    task automatic exp_wb(input logic [9:0] base, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
        mq.push_back('{1'b1, base, d0});
        mq.push_back('{1'b1, base + 10'd1, d1});
        mq.push_back('{1'b1, base + 10'd2, d2});
        mq.push_back('{1'b1, base + 10'd3, d3});
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [9:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_miss);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) fail("ready_timeout");
        read_en    = rd;
        write_en   = wr;
        address    = a;
        write_data = wd;
        sb.push_back('{wr, exp_d, exp_miss, cyc});
        @(posedge clk);
        #1;
        read_en  = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || mq.size() != 0 || !ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail("drain_timeout");
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", ready, 1'b1);
        check("rst_valid", valid, 1'b0);
        check("rst_miss", miss, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_read_data", read_data, 32'h0);
        check("rst_mem_addr", mem_addr, 10'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        mq.delete();
        miss_seen = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        check_reset_outputs();
    endtask

    task automatic run_seq();
        exp_refill(10'h000); do_req(1, 0, 10'h000, 0, 32'hC0DE_0000, 1);
        do_req(1, 0, 10'h003, 0, 32'hC0DE_0003, 0);
        exp_refill(10'h008); do_req(0, 1, 10'h00A, 32'h55, 0, 1);
        do_req(1, 0, 10'h00A, 0, 32'h55, 0);
        // Set 0: third tag evicts the LRU clean block, no memory writes.
        exp_refill(10'h010); do_req(1, 0, 10'h010, 0, 32'hC0DE_0010, 1);
        exp_refill(10'h020); do_req(1, 0, 10'h020, 0, 32'hC0DE_0020, 1);
        exp_refill(10'h000); do_req(1, 0, 10'h001, 0, 32'hC0DE_0001, 1);
        // Set 1: dirty 0x004 block is written back before the refill.
        exp_refill(10'h004); do_req(0, 1, 10'h004, 32'hAA, 0, 1);
        exp_refill(10'h014); do_req(1, 0, 10'h014, 0, 32'hC0DE_0014, 1);
        exp_wb(10'h004, 32'hAA, 32'hC0DE_0005, 32'hC0DE_0006, 32'hC0DE_0007);
        exp_refill(10'h024); do_req(1, 0, 10'h024, 0, 32'hC0DE_0024, 1);
        exp_refill(10'h004); do_req(1, 0, 10'h004, 0, 32'hAA, 1);
        do_req(1, 1, 10'h024, 32'h77, 0, 0);
        do_req(1, 0, 10'h024, 0, 32'h77, 0);
        exp_refill(10'h030); do_req(1, 0, 10'h030, 0, 32'hC0DE_0030, 1);
        // Stray request while stalled must be ignored.
        @(negedge clk);
        check("stalled_ready", ready, 1'b0);
        read_en = 1'b1;
        address = 10'h000;
        @(posedge clk);
        #1;
        read_en = 1'b0;
        drain();
    endtask

    initial begin
        int n;
        int base;
        apply_reset();
        max_delay = 0;
        run_seq();

        apply_reset();
        max_delay = 5;
        run_seq();

        // Reset in the middle of a refill.
        apply_reset();
        max_delay = 0;
        base = rd_acks;
        exp_refill(10'h100);
        do_req(1, 0, 10'h100, 0, 32'hC0DE_0100, 1);
        n = 0;
        @(negedge clk);
        while (rd_acks < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rd_acks < base + 2) fail("refill_progress_timeout");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrefill_rst_ready", ready, 1'b1);
        check("midrefill_rst_mem_req", mem_req, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        mq.delete();
        miss_seen = 1'b0;
        exp_refill(10'h100);
        do_req(1, 0, 10'h100, 0, 32'hC0DE_0100, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog_expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
